pmem_burst_adaptor: RTL
=======================

# pmem_burst_adaptor

Memory-side stage directly downstream of the cache eviction/write-back controller. Accepts whole-line read and write-back requests on the cache's `mem_action_stb`/`mem_action_cyc`/`mem_write` handshake and serialises them into fixed-length beat bursts on the physical-memory port. Returns a single `mem_resp` pulse per line, with the read line assembled on `line_rdata`.

## Interface
- `LINE_W`, default 256: cache line width in bits.
- `BEAT_W`, default 64: physical-memory data beat width in bits. `BEATS = LINE_W/BEAT_W` must be a power of two, ≥ 2.
- `ADDR_W`, default 32: byte address width.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_action_stb`  in  1  cache request strobe.
- `mem_action_cyc`  in  1  cache bus cycle; a request is `stb & cyc`.
- `mem_write`  in  1  1 = write-back line, 0 = line fill.
- `mem_address`  in  ADDR_W  line address; the low log2(LINE_W/8) bits are ignored.
- `line_wdata`  in  LINE_W  write-back line data.
- `line_rdata`  out  LINE_W  filled line; valid while `mem_resp` = 1.
- `mem_resp`  out  1  one-cycle completion pulse.
- `mem_retry`  out  1  `= stb & cyc & !mem_resp`, combinational.
- `pm_req`  out  1  burst active, held high for every beat.
- `pm_we`  out  1  burst direction.
- `pm_addr`  out  ADDR_W  current beat byte address.
- `pm_wdata`  out  BEAT_W  current write beat.
- `pm_rdata`  in  BEAT_W  read beat, sampled on `pm_ack`.
- `pm_ack`  in  1  per-beat acknowledge; may stall any number of cycles.

## Operation
- FSM states: IDLE, BURST, RESP.
- IDLE:
  - On `stb & cyc`, latch the line-aligned address, `mem_write`, and `line_wdata`.
  - Clear the beat counter `beat` (width log2(BEATS)) and go to BURST.
- BURST:
  - Drive `pm_req`=1 and `pm_we` = latched write flag.
  - `pm_addr = base + beat*(BEAT_W/8)`; beat offset bits are never carried into the line address.
  - `pm_wdata` = latched line slice `[beat*BEAT_W +: BEAT_W]`. Beat 0 is the least-significant slice and is sent first.
  - On `pm_ack`: for reads, store `pm_rdata` into slice `beat`; increment `beat`.
  - On `pm_ack` with `beat == BEATS-1`, go to RESP and drop `pm_req` from the next cycle.
- RESP:
  - `mem_resp`=1 for exactly one cycle, then IDLE.
  - `line_rdata` holds the assembled line from RESP until the next read completes.
  - Writes leave `line_rdata` unchanged.
- IDLE accepts a new request in the cycle immediately after RESP. The cache drops `stb` in that cycle, so there is no double accept.
- Request inputs are ignored outside IDLE; only latched values drive the burst.
- `pm_ack` while `pm_req`=0 is ignored.
- Reset, asynchronous, including mid-burst:
  - State goes to IDLE and `beat` to 0.
  - `pm_req`, `pm_we`, `mem_resp` = 0; `pm_addr`, `pm_wdata`, `line_rdata` = 0.
  - The partial burst is abandoned; no `mem_resp` is issued.
  - `mem_retry` still follows its inputs during reset.

## Timing
- Cycle T0: IDLE samples the request.
- Cycle T1: `pm_req` is high with beat 0 on the bus.
- With zero-wait acks at T1 through T(BEATS), `mem_resp` is at T(BEATS+1).
- Line latency = 2 + BEATS + total `pm_ack` stall cycles. Default: 6 cycles for 4 beats.
- `pm_addr`/`pm_wdata` change only in the cycle after an accepted beat and stay stable while `pm_ack`=0.
- All outputs are registered except `mem_retry`, and except `mem_resp`/`line_rdata` when bypass is enabled.

## Configuration
- `PMEM_RESP_BYPASS_EN`:
  - Defined: RESP is removed. `mem_resp` is asserted combinationally in the cycle of the final `pm_ack`. `line_rdata` presents the stored slices with the top slice taken directly from `pm_rdata`. FSM returns to IDLE on the next edge. Latency = 1 + BEATS + stalls.
  - Undefined: registered RESP state as described above.

## Test plan
- Read, address 0x0000_1234, zero-wait acks, beats 0x11..,0x22..,0x33..,0x44..:
  - `pm_addr` sequence = 0x1220, 0x1228, 0x1230, 0x1238.
  - `mem_resp` one pulse at T5.
  - `line_rdata` = {0x44..,0x33..,0x22..,0x11..}.
- Write-back, `line_wdata` = {D3,D2,D1,D0}: `pm_wdata` = D0..D3 in order, `pm_we`=1 throughout, one `mem_resp`, `line_rdata` unchanged.
- Read with 3 stall cycles before each ack:
  - `pm_addr`/`pm_wdata` stable during stalls.
  - `mem_resp` at T17.
  - `mem_retry`=1 every cycle before it.
- `rst_n` pulsed low after beat 1 of a read:
  - Outputs zero immediately, no `mem_resp`.
  - A following read completes normally from beat 0.
- Back-to-back write then read: the read is accepted the cycle after the write's `mem_resp`, with no lost or duplicated burst.
- With `PMEM_RESP_BYPASS_EN`, the zero-wait read from the first test: `mem_resp` at T4, and `line_rdata` top slice equals `pm_rdata` in that cycle.

Source files
------------

// File: rtl/pmem_burst_adaptor_if.sv
// Cache-side line handshake plus physical-memory beat port for pmem_burst_adaptor.
// slave = adaptor view, master = cache/memory environment view.
interface pmem_burst_adaptor_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
);
    logic              mem_action_stb;
    logic              mem_action_cyc;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] line_wdata;
    logic [LINE_W-1:0] line_rdata;
    logic              mem_resp;
    logic              mem_retry;
    logic              pm_req;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [BEAT_W-1:0] pm_wdata;
    logic [BEAT_W-1:0] pm_rdata;
    logic              pm_ack;

    modport slave (
        input  mem_action_stb, mem_action_cyc, mem_write, mem_address, line_wdata,
        input  pm_rdata, pm_ack,
        output line_rdata, mem_resp, mem_retry,
        output pm_req, pm_we, pm_addr, pm_wdata
    );

    modport master (
        output mem_action_stb, mem_action_cyc, mem_write, mem_address, line_wdata,
        output pm_rdata, pm_ack,
        input  line_rdata, mem_resp, mem_retry,
        input  pm_req, pm_we, pm_addr, pm_wdata
    );
endinterface

// File: rtl/pmem_burst_adaptor.sv
// Serialises whole-line cache reads/write-backs into BEATS-long bursts on the pmem port.
// Optional macro PMEM_RESP_BYPASS_EN: combinational mem_resp/line_rdata on the final ack.
module pmem_burst_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input logic                clk,
    input logic                rst_n,
    pmem_burst_adaptor_if.slave bus
);
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int BEAT_OFF_W = $clog2(BEAT_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

    state_t                r_state;
    logic [BEAT_IDX_W-1:0] r_beat;
    logic [ADDR_W-1:0]     r_base;
    logic                  r_we;
    logic [LINE_W-1:0]     r_wline;
    logic [LINE_W-1:0]     r_acc;
    logic [LINE_W-1:0]     r_line;
    logic                  r_pm_req;
    logic                  r_pm_we;
    logic [ADDR_W-1:0]     r_pm_addr;
    logic [BEAT_W-1:0]     r_pm_wdata;
`ifndef PMEM_RESP_BYPASS_EN
    logic                  r_resp;
`endif

    logic                  w_req;
    logic [ADDR_W-1:0]     w_aligned;
    logic [BEAT_IDX_W-1:0] w_next_beat;
    logic [ADDR_W-1:0]     w_next_addr;
    logic                  w_last_ack;
    logic [LINE_W-1:0]     w_final;

    assign w_req       = bus.mem_action_stb & bus.mem_action_cyc;
    assign w_aligned   = bus.mem_address & ~LINE_MASK;
    assign w_next_beat = r_beat + 1'b1;
    // Base is line-aligned, so OR-ing the beat offset can never carry into the line address.
    assign w_next_addr = r_base | (ADDR_W'(w_next_beat) << BEAT_OFF_W);
    assign w_last_ack  = (r_state == BURST) && bus.pm_ack && (&r_beat);

    always_comb begin
        w_final = r_acc;
        w_final[LINE_W-BEAT_W +: BEAT_W] = bus.pm_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_base     <= '0;
            r_we       <= 1'b0;
            r_wline    <= '0;
            r_acc      <= '0;
            r_line     <= '0;
            r_pm_req   <= 1'b0;
            r_pm_we    <= 1'b0;
            r_pm_addr  <= '0;
            r_pm_wdata <= '0;
`ifndef PMEM_RESP_BYPASS_EN
            r_resp     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_base     <= w_aligned;
                        r_we       <= bus.mem_write;
                        r_wline    <= bus.line_wdata;
                        r_beat     <= '0;
                        r_pm_req   <= 1'b1;
                        r_pm_we    <= bus.mem_write;
                        r_pm_addr  <= w_aligned;
                        r_pm_wdata <= bus.line_wdata[BEAT_W-1:0];
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (bus.pm_ack) begin
                        if (!r_we) r_acc[int'(r_beat)*BEAT_W +: BEAT_W] <= bus.pm_rdata;
                        r_beat <= w_next_beat;
                        if (&r_beat) begin
                            r_pm_req <= 1'b0;
                            r_pm_we  <= 1'b0;
                            if (!r_we) r_line <= w_final;
`ifdef PMEM_RESP_BYPASS_EN
                            r_state  <= IDLE;
`else
                            r_resp   <= 1'b1;
                            r_state  <= RESP;
`endif
                        end else begin
                            r_pm_addr  <= w_next_addr;
                            r_pm_wdata <= r_wline[int'(w_next_beat)*BEAT_W +: BEAT_W];
                        end
                    end
                end
`ifndef PMEM_RESP_BYPASS_EN
                RESP: begin
                    r_resp  <= 1'b0;
                    r_state <= IDLE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pm_req    = r_pm_req;
    assign bus.pm_we     = r_pm_we;
    assign bus.pm_addr   = r_pm_addr;
    assign bus.pm_wdata  = r_pm_wdata;
`ifdef PMEM_RESP_BYPASS_EN
    assign bus.mem_resp   = w_last_ack;
    assign bus.line_rdata = (w_last_ack && !r_we) ? w_final : r_line;
`else
    assign bus.mem_resp   = r_resp;
    assign bus.line_rdata = r_line;
`endif
    assign bus.mem_retry = w_req & ~bus.mem_resp;
endmodule
